// File: rtl/wb_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : wb_arbiter_if
// Brief    : Write-back arbiter bus: ALU result, load handshake, hazard query,
//            register-file write port and FIFO occupancy.
// Revision : 1.0
//==============================================================================
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ALU result from EX/MEM
    logic             EXMEM_wrEn;
    logic [4:0]       EXMEM_rD;
    logic [2:0]       EXMEM_ppp;
    logic [63:0]      EXMEM_data;

    // load / NIC return handshake
    logic             ld_valid;
    logic             ld_ready;
    logic [4:0]       ld_rD;
    logic [2:0]       ld_ppp;
    logic [63:0]      ld_data;

    // decode hazard query
    logic [4:0]       ID_rA;
    logic [4:0]       ID_rB;
    logic             pend_rA;
    logic             pend_rB;

    // register-file write port
    logic             WB_wrEn;
    logic [4:0]       WB_rD;
    logic [2:0]       WB_ppp;
    logic [63:0]      WB_rD_data;

    logic [CNT_W-1:0] fifo_count;

    // Pipeline / environment side
    modport master (
        output EXMEM_wrEn, EXMEM_rD, EXMEM_ppp, EXMEM_data,
        output ld_valid, ld_rD, ld_ppp, ld_data,
        output ID_rA, ID_rB,
        input  ld_ready, pend_rA, pend_rB,
        input  WB_wrEn, WB_rD, WB_ppp, WB_rD_data,
        input  fifo_count
    );

    // Arbiter side
    modport slave (
        input  EXMEM_wrEn, EXMEM_rD, EXMEM_ppp, EXMEM_data,
        input  ld_valid, ld_rD, ld_ppp, ld_data,
        input  ID_rA, ID_rB,
        output ld_ready, pend_rA, pend_rB,
        output WB_wrEn, WB_rD, WB_ppp, WB_rD_data,
        output fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : wb_arbiter
// Brief    : Owns the register-file write port. ALU results always win; load
//            returns are queued in a DEPTH-entry FIFO and drained in idle
//            slots. Optional macro WB_BYPASS_EN lets a load hit an empty,
//            idle port in its handshake cycle without being queued.
// Revision : 1.0
//==============================================================================
module wb_arbiter #(
    parameter int DEPTH = 4     // power of 2, >= 2; must match the interface
) (
    input  logic        clk,
    input  logic        reset,  // asynchronous, active-low
    wb_arbiter_if.slave bus
);
    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_valid;

    logic [4:0]       r_mem_rd   [DEPTH];
    logic [2:0]       r_mem_ppp  [DEPTH];
    logic [63:0]      r_mem_data [DEPTH];

    logic             r_wb_en;
    logic [4:0]       r_wb_rd;
    logic [2:0]       r_wb_ppp;
    logic [63:0]      r_wb_data;

    logic             w_full;
    logic             w_empty;
    logic             w_ld_fire;
    logic             w_bypass;
    logic             w_enq;
    logic             w_deq;

    logic             w_sel_en;
    logic [4:0]       w_sel_rd;
    logic [2:0]       w_sel_ppp;
    logic [63:0]      w_sel_data;

    logic [DEPTH-1:0] w_hit_a;
    logic [DEPTH-1:0] w_hit_b;

    assign w_full    = (r_count == C_FULL);
    assign w_empty   = (r_count == '0);

    // Ready looks only at the registered count, so a dequeue from a full
    // FIFO frees a slot one edge later.
    assign bus.ld_ready = !w_full && reset;
    assign w_ld_fire    = bus.ld_valid && bus.ld_ready;

`ifdef WB_BYPASS_EN
    assign w_bypass = w_ld_fire && !bus.EXMEM_wrEn && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_deq = !bus.EXMEM_wrEn && !w_empty;
    assign w_enq = w_ld_fire && !w_bypass;

    always_comb begin
        w_sel_en   = 1'b0;
        w_sel_rd   = r_mem_rd[r_rd_ptr];
        w_sel_ppp  = r_mem_ppp[r_rd_ptr];
        w_sel_data = r_mem_data[r_rd_ptr];
        if (bus.EXMEM_wrEn) begin
            w_sel_en   = 1'b1;
            w_sel_rd   = bus.EXMEM_rD;
            w_sel_ppp  = bus.EXMEM_ppp;
            w_sel_data = bus.EXMEM_data;
        end else if (!w_empty) begin
            w_sel_en   = 1'b1;
        end else if (w_bypass) begin
            w_sel_en   = 1'b1;
            w_sel_rd   = bus.ld_rD;
            w_sel_ppp  = bus.ld_ppp;
            w_sel_data = bus.ld_data;
        end
    end

    // Enqueue and dequeue never target the same slot: dequeue needs a
    // non-empty FIFO and enqueue a non-full one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= '0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_ppp  <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr           <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr]  <= 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr           <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr]  <= 1'b0;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_wb_en <= w_sel_en;
            if (w_sel_en) begin
                r_wb_rd   <= w_sel_rd;
                r_wb_ppp  <= w_sel_ppp;
                r_wb_data <= w_sel_data;
            end
        end
    end

    // Payload storage carries no reset; r_valid qualifies every entry.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_rd[r_wr_ptr]   <= bus.ld_rD;
            r_mem_ppp[r_wr_ptr]  <= bus.ld_ppp;
            r_mem_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
        assign w_hit_a[i] = r_valid[i] && (r_mem_rd[i] == bus.ID_rA);
        assign w_hit_b[i] = r_valid[i] && (r_mem_rd[i] == bus.ID_rB);
    end

    assign bus.pend_rA    = |w_hit_a;
    assign bus.pend_rB    = |w_hit_b;

    assign bus.WB_wrEn    = r_wb_en;
    assign bus.WB_rD      = r_wb_rd;
    assign bus.WB_ppp     = r_wb_ppp;
    assign bus.WB_rD_data = r_wb_data;
    assign bus.fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed + randomized bench for wb_arbiter against a queue model.
// Revision : 1.0
//==============================================================================
module tb_wb_arbiter;
    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  ppp;
        logic [63:0] data;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    ent_t        q[$];
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [2:0]  exp_ppp;
    logic [63:0] exp_data;
    bit          last_fire;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_pend(input logic [4:0] r);
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_state();
        check("wb_en",    64'(bus.WB_wrEn),    64'(exp_en));
        check("wb_rd",    64'(bus.WB_rD),      64'(exp_rd));
        check("wb_ppp",   64'(bus.WB_ppp),     64'(exp_ppp));
        check("wb_data",  bus.WB_rD_data,      exp_data);
        check("count",    64'(bus.fifo_count), 64'(q.size()));
        check("ld_ready", 64'(bus.ld_ready),   64'(reset && (q.size() != DEPTH)));
        check("pend_rA",  64'(bus.pend_rA),    64'(model_pend(bus.ID_rA)));
        check("pend_rB",  64'(bus.pend_rB),    64'(model_pend(bus.ID_rB)));
    endtask

    // Apply one clock of the model to the current inputs, then compare.
    task automatic tick();
        bit   fire;
        bit   byp;
        ent_t ld;
        ent_t h;
        fire = 1'b0;
        byp  = 1'b0;
        if (!reset) begin
            q.delete();
            exp_en = 1'b0; exp_rd = '0; exp_ppp = '0; exp_data = '0;
        end else begin
            fire = bus.ld_valid && (q.size() != DEPTH);
            ld   = '{bus.ld_rD, bus.ld_ppp, bus.ld_data};
            if (bus.EXMEM_wrEn) begin
                exp_en = 1'b1; exp_rd = bus.EXMEM_rD;
                exp_ppp = bus.EXMEM_ppp; exp_data = bus.EXMEM_data;
            end else if (q.size() != 0) begin
                h = q.pop_front();
                exp_en = 1'b1; exp_rd = h.rd; exp_ppp = h.ppp; exp_data = h.data;
            end else if (BYPASS && fire) begin
                byp = 1'b1;
                exp_en = 1'b1; exp_rd = ld.rd; exp_ppp = ld.ppp; exp_data = ld.data;
            end else begin
                exp_en = 1'b0;
            end
            if (fire && !byp) q.push_back(ld);
        end
        last_fire = fire;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic offer(input logic [4:0] r);
        bus.ld_valid = 1'b1;
        bus.ld_rD    = r;
        bus.ld_ppp   = r[2:0];
        bus.ld_data  = {$urandom, $urandom};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] got [8];
        int         n_wr;
        int         nxt;

        // Reset held with traffic present
        bus.EXMEM_wrEn = 1'b1; bus.EXMEM_rD = 5'd3; bus.EXMEM_ppp = 3'd2;
        bus.EXMEM_data = 64'h1111;
        bus.ld_valid = 1'b1; bus.ld_rD = 5'd4; bus.ld_ppp = 3'd1; bus.ld_data = 64'h2222;
        bus.ID_rA = 5'd4; bus.ID_rB = 5'd0;
        exp_en = 1'b0; exp_rd = '0; exp_ppp = '0; exp_data = '0;
        last_fire = 1'b0;
        @(posedge clk);
        #1;
        check_state();
        check("rst_ready", 64'(bus.ld_ready), 64'd0);
        tick();
        tick();
        bus.EXMEM_wrEn = 1'b0;
        bus.ld_valid   = 1'b0;
        reset          = 1'b1;
        tick();
        check("rst_release_no_write", 64'(bus.WB_wrEn), 64'd0);

        // ALU only
        bus.EXMEM_wrEn = 1'b1; bus.EXMEM_rD = 5'd5; bus.EXMEM_ppp = 3'b000;
        bus.EXMEM_data = 64'hDEADBEEF00000001;
        tick();
        check("alu_en",   64'(bus.WB_wrEn), 64'd1);
        check("alu_rd",   64'(bus.WB_rD),   64'd5);
        check("alu_data", bus.WB_rD_data,   64'hDEADBEEF00000001);
        bus.EXMEM_wrEn = 1'b0;
        tick();
        check("alu_hold_rd", 64'(bus.WB_rD), 64'd5);

        // Single load, empty FIFO, idle ALU
        offer(5'd9);
        tick();
        bus.ld_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check("byp_lat1_en", 64'(bus.WB_wrEn), 64'd1);
        check("byp_lat1_rd", 64'(bus.WB_rD),   64'd9);
        check("byp_not_queued", 64'(bus.fifo_count), 64'd0);
`else
        check("nobyp_lat1_en", 64'(bus.WB_wrEn), 64'd0);
        tick();
        check("nobyp_lat2_en", 64'(bus.WB_wrEn), 64'd1);
        check("nobyp_lat2_rd", 64'(bus.WB_rD),   64'd9);
`endif
        tick();

        // Fill under continuous ALU traffic, then drain across the wrap
        bus.EXMEM_wrEn = 1'b1; bus.EXMEM_rD = 5'd20; bus.EXMEM_ppp = 3'd1;
        nxt = 1;
        offer(5'd1);
        for (int k = 0; k < 6; k++) begin
            bus.EXMEM_data = {32'hA1A10000, k};
            tick();
            if (last_fire) begin
                if (nxt < 6) begin nxt++; offer(5'(nxt)); end
                else bus.ld_valid = 1'b0;
            end
        end
        check("full_count", 64'(bus.fifo_count), 64'd4);
        check("full_ready", 64'(bus.ld_ready),   64'd0);
        bus.EXMEM_wrEn = 1'b0;
        n_wr = 0;
        for (int k = 0; k < 20 && n_wr < 6; k++) begin
            tick();
            if (last_fire) begin
                if (nxt < 6) begin nxt++; offer(5'(nxt)); end
                else bus.ld_valid = 1'b0;
            end
            if (bus.WB_wrEn) begin got[n_wr] = bus.WB_rD; n_wr++; end
        end
        check("drain_writes", 64'(n_wr), 64'd6);
        for (int i = 0; i < 6; i++) check("drain_order", 64'(got[i]), 64'(i + 1));

        // Hazard and ALU/head conflict
        bus.EXMEM_wrEn = 1'b1; bus.EXMEM_rD = 5'd7; bus.EXMEM_data = 64'h77;
        offer(5'd12);
        bus.ID_rA = 5'd12; bus.ID_rB = 5'd3;
        tick();
        bus.ld_valid = 1'b0;
        check("haz_pend_a", 64'(bus.pend_rA),    64'd1);
        check("haz_pend_b", 64'(bus.pend_rB),    64'd0);
        check("conf_count", 64'(bus.fifo_count), 64'd1);
        tick();
        check("conf_alu_first", 64'(bus.WB_rD),      64'd7);
        check("conf_head_held", 64'(bus.fifo_count), 64'd1);
        bus.EXMEM_wrEn = 1'b0;
        tick();
        check("conf_head_next", 64'(bus.WB_rD),      64'd12);
        check("conf_count_dec", 64'(bus.fifo_count), 64'd0);
        check("haz_clear",      64'(bus.pend_rA),    64'd0);

        // Reset in the middle of a drain
        bus.EXMEM_wrEn = 1'b1; bus.EXMEM_rD = 5'd30;
        for (int k = 0; k < 3; k++) begin
            offer(5'(16 + k));
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.EXMEM_wrEn = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        q.delete();
        exp_en = 1'b0; exp_rd = '0; exp_ppp = '0; exp_data = '0;
        #1;
        check_state();
        check("rst_mid_count", 64'(bus.fifo_count), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_no_write", 64'(bus.WB_wrEn), 64'd0);

        // Randomized traffic
        bus.ld_valid = 1'b0;
        last_fire = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bus.EXMEM_wrEn = ($urandom_range(0, 99) < ((c < 150) ? 70 : 35));
            bus.EXMEM_rD   = 5'($urandom);
            bus.EXMEM_ppp  = 3'($urandom);
            bus.EXMEM_data = {$urandom, $urandom};
            if (!bus.ld_valid || last_fire) begin
                if ($urandom_range(0, 1) == 1) offer(5'($urandom_range(0, 31)));
                else bus.ld_valid = 1'b0;
            end
            if (q.size() != 0 && $urandom_range(0, 1) == 1)
                bus.ID_rA = q[$urandom_range(0, q.size() - 1)].rd;
            else
                bus.ID_rA = 5'($urandom);
            bus.ID_rB = 5'($urandom);
            tick();
            if (c == 250) begin
                reset = 1'b0;
                bus.ld_valid = 1'b0;
                tick();
                reset = 1'b1;
                last_fire = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the register file's single write port (`WB_wrEn`, `WB_rD`, `WB_ppp`, `WB_rD_data`), which the decode stage's register file consumes.

- Merges two result sources onto that one port:
  - ALU results arriving from EX/MEM every cycle, with no back-pressure.
  - Load/NIC return data arriving on a ready/valid handshake.
- ALU results always win the port. Load returns are queued in a small FIFO and drained in idle slots.
- Reports pending-load hazards on the decode source registers so the hazard unit can stall.

## Interface
Parameters:
- `DEPTH`, default 4: load FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `EXMEM_wrEn`  in  1  ALU result valid this cycle.
- `EXMEM_rD`  in  5  ALU destination register.
- `EXMEM_ppp`  in  3  ALU participation field.
- `EXMEM_data`  in  64  ALU result.
- `ld_valid`  in  1  load return offered.
- `ld_ready`  out  1  arbiter can accept a load return.
- `ld_rD`  in  5  load destination register.
- `ld_ppp`  in  3  load participation field.
- `ld_data`  in  64  load data.
- `ID_rA`, `ID_rB`  in  5 each  decode source registers, used for the hazard check.
- `pend_rA`, `pend_rB`  out  1 each  that source matches a valid FIFO entry.
- `WB_wrEn`  out  1  register file write enable.
- `WB_rD`  out  5  register file write address.
- `WB_ppp`  out  3  register file participation field.
- `WB_rD_data`  out  64  register file write data.
- `fifo_count`  out  clog2(DEPTH)+1  current number of FIFO entries.

## Operation
- **Load handshake.** A transfer happens on a rising edge where `ld_valid && ld_ready`.
  - The source holds `ld_rD`/`ld_ppp`/`ld_data` stable until the transfer.
  - `ld_ready = (fifo_count != DEPTH) && reset`. It is driven from the registered count, not from same-cycle dequeue.
- **FIFO.** Circular buffer with read and write pointers of width clog2(DEPTH); both wrap from DEPTH-1 to 0.
  - `fifo_count` is incremented on enqueue and decremented on dequeue. Simultaneous enqueue and dequeue leaves it unchanged.
- **Selection each cycle, in priority order:**
  1. `EXMEM_wrEn`=1: write the ALU result; the FIFO head is held.
  2. Otherwise, if the FIFO is non-empty: dequeue the head and write it.
  3. Otherwise, with `WB_BYPASS_EN`: if a load transfer occurs this cycle, write it directly; it is not enqueued.
  4. Otherwise: `WB_wrEn`=0.
- **Output register.** The selected write is registered into `WB_*`.
  - `WB_rD`/`WB_ppp`/`WB_rD_data` hold their last values whenever `WB_wrEn`=0.
- **Hazard flags.** `pend_rA`/`pend_rB` are combinational matches of `ID_rA`/`ID_rB` against the `rD` of every valid FIFO entry.
  - Register 0 is not special.
  - A `ld_rD` being enqueued in the current cycle is not included.
- **Write ordering.** The pipeline stalls any ALU write whose `rD` hits a pending entry, so this block does no write-after-write resolution.
- **Data path.** `ppp` and data pass through unmodified; the block does no arithmetic on them.

## Timing
- **Reset** (asynchronous, `reset`=0):
  - Pointers and `fifo_count` go to 0; stored entries are ignored.
  - `WB_wrEn`=0, `WB_rD`=0, `WB_ppp`=0, `WB_rD_data`=0.
  - `ld_ready`=0 and `pend_rA`=`pend_rB`=0.
  - Reset mid-drain discards all queued entries with no write.
- **ALU latency:** `EXMEM_wrEn` at edge N gives `WB_wrEn`=1 after edge N+1.
- **Load latency, empty FIFO, no ALU traffic:** 1 cycle with bypass, 2 cycles without.
- **Starvation:** a continuous ALU stream blocks draining indefinitely. While full, `ld_ready` stays 0.
- **Full FIFO:** a dequeue at edge N raises `ld_ready` only after edge N.
- **Empty FIFO:** dequeue is never attempted.
- **Sustained throughput:** one write per cycle.

## Configuration
- **`WB_BYPASS_EN` defined:** a load return can be written in its handshake cycle when the FIFO is empty and `EXMEM_wrEn`=0; it is never enqueued.
- **`WB_BYPASS_EN` undefined:** every load return is enqueued, adding 1 cycle of latency. Outputs are otherwise identical.

## Test plan
- **Reset:** hold `reset`=0 with `ld_valid`=1 and `EXMEM_wrEn`=1 → all outputs 0, `ld_ready`=0, no write after release.
- **ALU only:** `EXMEM_wrEn`=1, `rD`=5, `ppp`=000, data=0xDEADBEEF00000001 → next cycle `WB_wrEn`=1 with `WB_rD`=5 and that data.
- **Bypass on/off:** empty FIFO, single load with `rD`=9, no ALU traffic → `WB_wrEn` 1 cycle later with bypass, 2 cycles later without.
- **Fill and wrap, DEPTH=4:** `EXMEM_wrEn` held 1; offer loads `rD`=1..6:
  - 4 accepted, then `ld_ready`=0 and `fifo_count`=4.
  - Drop the ALU traffic → writes `rD` 1,2,3,4 in order, then 5 and 6 after the pointers wrap.
- **Hazard:** FIFO holds `rD`=12; `ID_rA`=12, `ID_rB`=3 → `pend_rA`=1, `pend_rB`=0. `pend_rA` clears the cycle after 12 is dequeued.
- **Conflict:** ALU write and FIFO head in the same cycle → ALU written first, head written next cycle, `fifo_count` decremented once.
